// File: rtl/pixmem_pkg.sv
// Shared constants, FSM state type and credit helper for the pixel-memory scan master.
package pixmem_pkg;

  localparam int unsigned PIX_DIM       = 512;
  localparam int unsigned ADDR_W        = 18;
  localparam int unsigned WORD_BITS     = 32;
  localparam int unsigned WORDS_PER_ROW = PIX_DIM / WORD_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_t;

  // Reads in flight plus pixels already sitting in the pack register.
  function automatic logic [6:0] credit_of(input logic [5:0] pending, input logic [5:0] bits);
    return {1'b0, pending} + {1'b0, bits};
  endfunction

endpackage

// File: rtl/pixmem_scan_master_if.sv
// Avalon-MM read master bus plus packed-word valid/ready stream.
interface pixmem_scan_master_if #(
  parameter int unsigned DIM_LOG2 = 9
);
  import pixmem_pkg::*;

  logic [2*DIM_LOG2-1:0] m_address;
  logic                  m_read;
  logic                  m_waitrequest;
  logic [WORD_BITS-1:0]  m_readdata;
  logic                  m_readdatavalid;
  logic [WORD_BITS-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIM_LOG2-1:0]   out_row;
  logic [DIM_LOG2-6:0]   out_col;
  logic                  out_last;

  modport master (
    output m_address, m_read, out_data, out_valid, out_row, out_col, out_last,
    input  m_waitrequest, m_readdata, m_readdatavalid, out_ready
  );

  modport slave (
    input  m_address, m_read, out_data, out_valid, out_row, out_col, out_last,
    output m_waitrequest, m_readdata, m_readdatavalid, out_ready
  );

endinterface

// File: rtl/pixmem_scan_master_pack32.sv
// Packs 32 pixel bits into a word and hands it to a one-entry output register.
module pixmem_pack32
  import pixmem_pkg::*;
#(
  parameter int unsigned DIM_LOG2 = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 out_ready,
  output logic [WORD_BITS-1:0] out_data,
  output logic                 out_valid,
  output logic [DIM_LOG2-1:0]  out_row,
  output logic [DIM_LOG2-6:0]  out_col,
  output logic                 out_last,
  output logic [5:0]           bit_count
);

  localparam int unsigned WCNT_W = 2*DIM_LOG2 - 5;

  logic [WORD_BITS-1:0] pack;
  logic [4:0]           bitidx;
  logic                 full;
  logic [WCNT_W-1:0]    wcnt;
  logic                 wrap;
  logic                 out_free;
  logic                 load;
  logic [WORD_BITS-1:0] word;

  // Word completion, output-slot availability and the word to be loaded
  always_comb begin
    wrap     = bit_valid && (bitidx == 5'd31);
    out_free = !out_valid || out_ready;
    load     = (full || wrap) && out_free;
    word     = pack;
    if (wrap) word[31] = bit_in;
    bit_count = full ? 6'd32 : {1'b0, bitidx};
  end

  // Pack register, full flag and output register with its word position
  always_ff @(posedge clk) begin
    if (reset) begin
      pack      <= '0;
      bitidx    <= '0;
      full      <= 1'b0;
      wcnt      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (bit_valid) begin
        pack[bitidx] <= bit_in;
        bitidx       <= bitidx + 5'd1;
      end
      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
        out_row   <= wcnt[WCNT_W-1 -: DIM_LOG2];
        out_col   <= wcnt[DIM_LOG2-6:0];
        out_last  <= &wcnt;
        wcnt      <= wcnt + WCNT_W'(1);
        full      <= 1'b0;
      end else begin
        // A completed word that cannot move out parks here and blocks issue.
        if (wrap) full <= 1'b1;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pixmem_scan_master.sv
// Full-frame raster read master: issues pixel reads, counts credit, packs words.
module pixmem_scan_master
  import pixmem_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned DIM_LOG2    = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  pixmem_scan_master_if.master bus
);

  localparam int unsigned AW = 2*DIM_LOG2;

  scan_state_t   state;
  scan_state_t   next_state;
  logic [AW-1:0] addr;
  logic [5:0]    pending;
  logic [5:0]    bit_count;
  logic [6:0]    credit;
  logic          accept;
  logic          resp;
  logic          last_read;
  logic          unused_readdata;

  assign bus.m_address   = addr;
  assign credit          = credit_of(pending, bit_count);
  assign resp            = bus.m_readdatavalid && (state == ST_SCAN || state == ST_DRAIN);
  assign last_read       = (addr == '1);
  assign unused_readdata = ^bus.m_readdata[WORD_BITS-1:1];

  // Next-state decode, read issue and status outputs
  always_comb begin
    next_state = state;
    bus.m_read = 1'b0;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) next_state = ST_SCAN;
      end
      ST_SCAN: begin
        busy       = 1'b1;
        bus.m_read = (pending < 6'(MAX_PENDING)) && (credit < 7'd32);
        accept     = bus.m_read && !bus.m_waitrequest;
        if (accept && last_read) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (bus.out_valid && bus.out_ready && bus.out_last) next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Read address and outstanding-read counter
  always_ff @(posedge clk) begin
    if (reset) begin
      addr    <= '0;
      pending <= '0;
    end else begin
      if (accept) addr <= addr + AW'(1);
      if (accept && !resp)      pending <= pending + 6'd1;
      else if (resp && !accept) pending <= pending - 6'd1;
    end
  end

  pixmem_pack32 #(.DIM_LOG2(DIM_LOG2)) u_pack (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (resp),
    .bit_in    (bus.m_readdata[0]),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_row   (bus.out_row),
    .out_col   (bus.out_col),
    .out_last  (bus.out_last),
    .bit_count (bit_count)
  );

endmodule

// File: tb/tb_pixmem_scan_master.sv
// Directed + randomized bench for pixmem_scan_master on a reduced 64x64 frame.
module tb_pixmem_scan_master;

  localparam int unsigned D      = 6;
  localparam int unsigned SIDE   = 1 << D;
  localparam int unsigned NPIX   = SIDE * SIDE;
  localparam int unsigned WPR    = SIDE / 32;
  localparam int unsigned NWORDS = NPIX / 32;
  localparam int unsigned MAXP   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  pixmem_scan_master_if #(.DIM_LOG2(D)) bus ();

  pixmem_scan_master #(.MAX_PENDING(MAXP), .DIM_LOG2(D)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int unsigned cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          mem [NPIX];

  int unsigned wait_mode = 0, lat_mode = 0, lat_fix = 1, rdy_mode = 0;
  int unsigned hold_lo = 0, hold_hi = 0;
  int unsigned reads = 0, exp_addr = 0, addr_viol = 0, stall_viol = 0, hold_viol = 0;
  int unsigned max_out = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0;
  logic        win_mread = 1'b1, win_valid = 1'b0;
  int unsigned rq_due [$];
  bit          rq_bit [$];
  logic [31:0] cap_data [$];
  logic [7:0]  cap_tag [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int unsigned w);
    logic [31:0] v;
    int unsigned row = w / WPR;
    int unsigned col = w % WPR;
    for (int unsigned k = 0; k < 32; k++) v[k] = mem[row*SIDE + col*32 + k];
    return v;
  endfunction

  function automatic logic [7:0] model_tag(input int unsigned w);
    return {(w == NWORDS-1) ? 1'b1 : 1'b0, 6'(w / WPR), 1'(w % WPR)};
  endfunction

  // Avalon slave: wait pattern, in-order responses with per-read latency
  initial begin : slave
    bit              wr;
    bit              prev_stall;
    logic [2*D-1:0]  prev_addr;
    int unsigned     lat;
    prev_stall = 1'b0;
    prev_addr  = '0;
    bus.m_waitrequest   = 1'b0;
    bus.m_readdatavalid = 1'b0;
    bus.m_readdata      = '0;
    forever begin
      @(negedge clk);
      case (wait_mode)
        1:       wr = (cyc % 4) != 0;
        2:       wr = ($urandom_range(0, 2) == 0);
        default: wr = 1'b0;
      endcase
      bus.m_waitrequest = wr;
      if (prev_stall && !(bus.m_read === 1'b1 && bus.m_address === prev_addr)) stall_viol++;
      prev_stall = (bus.m_read === 1'b1) && wr;
      prev_addr  = bus.m_address;
      if (bus.m_read === 1'b1 && !wr) begin
        reads++;
        if (int'(bus.m_address) != exp_addr) addr_viol++;
        exp_addr = (exp_addr + 1) % NPIX;
        lat = (lat_mode != 0) ? $urandom_range(1, 6) : lat_fix;
        rq_due.push_back(cyc + lat);
        rq_bit.push_back(mem[bus.m_address]);
      end
      if (rq_due.size() != 0 && rq_due[0] <= cyc) begin
        bus.m_readdata      = {31'($urandom), rq_bit[0]};
        bus.m_readdatavalid = 1'b1;
        void'(rq_due.pop_front());
        void'(rq_bit.pop_front());
      end else begin
        bus.m_readdatavalid = 1'b0;
        bus.m_readdata      = $urandom;
      end
      if (rq_due.size() > max_out) max_out = rq_due.size();
    end
  end

  // Stream sink: ready pattern, word capture, hold and done monitoring
  initial begin : sink
    bit          r;
    bit          prev_hold;
    logic [31:0] hd;
    logic [7:0]  ht;
    logic [7:0]  tag;
    prev_hold     = 1'b0;
    hd            = '0;
    ht            = '0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1:       r = !(cyc >= hold_lo && cyc < hold_hi);
        2:       r = ($urandom_range(0, 3) != 0);
        default: r = 1'b1;
      endcase
      bus.out_ready = r;
      tag = {bus.out_last, bus.out_row, bus.out_col};
      if (prev_hold && !(bus.out_valid === 1'b1 && bus.out_data === hd && tag === ht)) hold_viol++;
      prev_hold = (bus.out_valid === 1'b1) && !r;
      hd = bus.out_data;
      ht = tag;
      if (rdy_mode == 1 && cyc + 1 == hold_hi) begin
        win_mread = bus.m_read;
        win_valid = bus.out_valid;
      end
      if (bus.out_valid === 1'b1 && r) begin
        cap_data.push_back(bus.out_data);
        cap_tag.push_back(tag);
        if (bus.out_last === 1'b1) last_cyc = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [63:0] idle_view();
    return 64'({busy, done, bus.m_read, bus.m_address, bus.out_valid, bus.out_data,
                bus.out_row, bus.out_col, bus.out_last});
  endfunction

  task automatic run_frame(input string tag, input int unsigned restart_at, output int unsigned cycles);
    int unsigned d0;
    int unsigned t0;
    bit          got;
    cap_data.delete();
    cap_tag.delete();
    exp_addr   = 0;
    reads      = 0;
    addr_viol  = 0;
    stall_viol = 0;
    hold_viol  = 0;
    max_out    = 0;
    d0         = done_cnt;
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_first_read"}, 64'({bus.m_read, busy, bus.m_address}), 64'({1'b1, 1'b1, 12'd0}));
    got = 1'b0;
    for (int unsigned i = 1; i < 30000 && !got; i++) begin
      @(negedge clk);
      start = (restart_at != 0 && i == restart_at);
      if (done === 1'b1) got = 1'b1;
    end
    start  = 1'b0;
    cycles = cyc - t0;
    check({tag, "_done_seen"}, 64'(got), 64'(1));
    repeat (4) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
    check({tag, "_done_after_last"}, 64'(done_cyc), 64'(last_cyc + 1));
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
    check({tag, "_reads"}, 64'(reads), 64'(NPIX));
    check({tag, "_addr_order"}, 64'(addr_viol), 64'(0));
    check({tag, "_stall_stable"}, 64'(stall_viol), 64'(0));
    check({tag, "_out_hold"}, 64'(hold_viol), 64'(0));
    check({tag, "_max_pending_ok"}, 64'(max_out <= MAXP), 64'(1));
    check({tag, "_nwords"}, 64'(cap_data.size()), 64'(NWORDS));
    for (int unsigned w = 0; w < NWORDS && w < cap_data.size(); w++) begin
      check($sformatf("%s_w%0d_data", tag, w), 64'(cap_data[w]), 64'(model_word(w)));
      check($sformatf("%s_w%0d_pos", tag, w), 64'(cap_tag[w]), 64'(model_tag(w)));
    end
  endtask

  task automatic clear_image();
    for (int unsigned i = 0; i < NPIX; i++) mem[i] = 1'b0;
  endtask

  task automatic random_image();
    for (int unsigned i = 0; i < NPIX; i++) mem[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic three_pixel_image();
    clear_image();
    mem[0]         = 1'b1;
    mem[33]        = 1'b1;
    mem[NPIX - 1]  = 1'b1;
  endtask

  initial begin : main
    int unsigned cycles;
    int unsigned d0;
    bit          hit;

    repeat (3) @(negedge clk);
    check("reset_outputs", idle_view(), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", idle_view(), 64'(0));

    // Empty frame, zero-wait slave, always-ready sink
    clear_image();
    lat_fix = 1;
    run_frame("t1", 0, cycles);
    check("t1_throughput", 64'(cycles <= 4600), 64'(1));

    // Three isolated pixels
    three_pixel_image();
    run_frame("t2", 0, cycles);

    // Heavy stalls with long response latency
    wait_mode = 1;
    lat_fix   = 5;
    run_frame("t3", 0, cycles);
    wait_mode = 0;
    lat_fix   = 1;

    // Sink blocked for 100 cycles mid-frame
    random_image();
    rdy_mode = 1;
    hold_lo  = cyc + 1500;
    hold_hi  = hold_lo + 100;
    run_frame("t4", 0, cycles);
    check("t4_read_stalled", 64'(win_mread), 64'(0));
    check("t4_word_held", 64'(win_valid), 64'(1));
    rdy_mode = 0;

    // Reset mid-scan with reads in flight, then stale responses, then rescan
    random_image();
    lat_fix  = 4;
    exp_addr = 0;
    reads    = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int unsigned i = 0; i < 5000 && !hit; i++) begin
      @(negedge clk);
      if (reads >= 1000) hit = 1'b1;
    end
    check("t5_reach_read_1000", 64'(hit), 64'(1));
    d0    = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_reset_outputs", idle_view(), 64'(0));
    check("t5_stale_in_flight", 64'(rq_due.size() != 0), 64'(1));
    repeat (12) @(negedge clk);
    check("t5_idle_after_stale", idle_view(), 64'(0));
    check("t5_no_done", 64'(done_cnt - d0), 64'(0));
    run_frame("t5", 0, cycles);
    lat_fix = 1;

    // Second start pulse during SCAN is ignored
    random_image();
    run_frame("t6", 500, cycles);

    // Random stalls, random latency, random sink back-pressure
    random_image();
    wait_mode = 2;
    lat_mode  = 1;
    rdy_mode  = 2;
    run_frame("t7", 0, cycles);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
